// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the divided-clock detector
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;

    // All-ones value of a w-bit counter, i.e. 2^w - 1.
    function automatic logic [63:0] sat_val(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - CLK_IN sample chain and rising-edge detect; CLK_DIV_DETECT_SYNC_EN adds two synchronizer flops
module clk_edge_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLK_IN,
    output logic s,
    output logic rise
);

    logic s0;
    logic s_prev;

`ifdef CLK_DIV_DETECT_SYNC_EN
    logic s1;
    logic s2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s0     <= CLK_IN;
            s1     <= s0;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign s = s2;
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s0     <= CLK_IN;
            s_prev <= s0;
        end
    end

    assign s = s0;
`endif

    assign rise = s & ~s_prev;

endmodule

// File: rtl/clk_div_detect.sv
// rtl/clk_div_detect.sv - period/high/low measurement of a divided clock against CLK (option: CLK_DIV_DETECT_SYNC_EN)
module clk_div_detect
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLK_IN,
    input  logic             EN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] LOW_CNT,
    output logic             ODD,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             s;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;

    clk_edge_sync u_edge (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CLK_IN (CLK_IN),
        .s      (s),
        .rise   (rise)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            PERIOD     <= '0;
            HIGH_CNT   <= '0;
            LOW_CNT    <= '0;
            ODD        <= 1'b0;
            VALID      <= 1'b0;
            TIMEOUT    <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (!EN) begin
                state      <= IDLE;
                period_cnt <= '0;
                high_cnt   <= '0;
                TIMEOUT    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        state      <= ARM;
                    end
                    // First edge after arming only starts the count.
                    ARM: begin
                        if (rise) begin
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                            state      <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            PERIOD     <= period_cnt;
                            HIGH_CNT   <= high_cnt;
                            LOW_CNT    <= period_cnt - high_cnt;
                            ODD        <= period_cnt[0];
                            VALID      <= 1'b1;
                            TIMEOUT    <= 1'b0;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                        end else if (period_cnt == SAT) begin
                            TIMEOUT    <= 1'b1;
                            period_cnt <= '0;
                            high_cnt   <= '0;
                            state      <= ARM;
                        end else begin
                            period_cnt <= period_cnt + ONE;
                            high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, s};
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_detect.sv
// tb/tb_clk_div_detect.sv - directed bench for clk_div_detect (CNT_W=16 and CNT_W=4 instances)
module tb_clk_div_detect;

`ifdef CLK_DIV_DETECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_in = 1'b0;
    logic        en16 = 1'b0;
    logic        en4 = 1'b0;

    logic [15:0] period16, high16, low16;
    logic        odd16, valid16, timeout16;
    logic [3:0]  period4, high4, low4;
    logic        odd4, valid4, timeout4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clk_div_detect #(.CNT_W(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .CLK_IN(clk_in), .EN(en16),
        .PERIOD(period16), .HIGH_CNT(high16), .LOW_CNT(low16),
        .ODD(odd16), .VALID(valid16), .TIMEOUT(timeout16)
    );

    clk_div_detect #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .CLK_IN(clk_in), .EN(en4),
        .PERIOD(period4), .HIGH_CNT(high4), .LOW_CNT(low4),
        .ODD(odd4), .VALID(valid4), .TIMEOUT(timeout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        clk_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic rearm(input bit sel4);
        en16 = 1'b0;
        en4  = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        if (sel4) en4 = 1'b1;
        else      en16 = 1'b1;
        step(1'b0);
    endtask

    // Second rising edge (at i = P) is the first to produce VALID, one edge later.
    task automatic run_wave(input int hi, input int lo, input int n, input bit sel4, input string tag);
        int  p;
        bit  exp_v;
        p = hi + lo;
        for (int i = 0; i < n; i++) begin
            step((i % p) < hi);
            exp_v = (i >= p + 1 + LAT) && (((i - p - 1 - LAT) % p) == 0);
            chk(tag, sel4 ? valid4 : valid16, exp_v);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period",  period16,  0);
        chk("rst_high",    high16,    0);
        chk("rst_low",     low16,     0);
        chk("rst_odd",     odd16,     0);
        chk("rst_valid",   valid16,   0);
        chk("rst_timeout", timeout16, 0);
        chk("rst_period4", period4,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 high / 2 low
        rearm(1'b0);
        run_wave(3, 2, 22, 1'b0, "t1_valid");
        chk("t1_period", period16, 5);
        chk("t1_high",   high16,   3);
        chk("t1_low",    low16,    2);
        chk("t1_odd",    odd16,    1);

        // 4 high / 4 low
        rearm(1'b0);
        run_wave(4, 4, 26, 1'b0, "t2_valid");
        chk("t2_period", period16, 8);
        chk("t2_high",   high16,   4);
        chk("t2_low",    low16,    4);
        chk("t2_odd",    odd16,    0);

        // EN dropped mid-period, then re-enabled with a new ratio
        rearm(1'b0);
        run_wave(4, 4, 13, 1'b0, "t4_valid_pre");
        en16 = 1'b0;
        step(1'b1);
        chk("t4_off_valid",   valid16,   0);
        chk("t4_off_period",  period16,  8);
        chk("t4_off_high",    high16,    4);
        chk("t4_off_timeout", timeout16, 0);
        rearm(1'b0);
        chk("t4_hold_period", period16, 8);
        run_wave(2, 4, 16, 1'b0, "t4_valid");
        chk("t4_period", period16, 6);
        chk("t4_high",   high16,   2);
        chk("t4_low",    low16,    4);
        chk("t4_odd",    odd16,    0);

        // asynchronous reset mid-period
        rearm(1'b0);
        run_wave(3, 2, 9, 1'b0, "t5_valid_pre");
        chk("t5_pre_period", period16, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_period", period16, 0);
        chk("t5_rst_high",   high16,   0);
        chk("t5_rst_low",    low16,    0);
        chk("t5_rst_odd",    odd16,    0);
        chk("t5_rst_valid",  valid16,  0);
        @(negedge clk);
        rst_n = 1'b1;
        rearm(1'b0);
        run_wave(5, 2, 17, 1'b0, "t5_valid");
        chk("t5_period", period16, 7);
        chk("t5_high",   high16,   5);
        chk("t5_low",    low16,    2);
        chk("t5_odd",    odd16,    1);

        // CNT_W=4: one edge then stuck low -> timeout after 15 cycles in MEAS
        rearm(1'b1);
        step(1'b1);
        for (int j = 1; j <= 16 + LAT; j++) begin
            step(1'b0);
            chk("t3_timeout", timeout4, (j >= 16 + LAT));
            chk("t3_valid",   valid4,   0);
        end
        for (int k = 0; k <= 4 + LAT; k++) begin
            step((k % 3) == 0);
            chk("t3_re_valid",   valid4,   (k == 4 + LAT));
            chk("t3_re_timeout", timeout4, (k < 4 + LAT));
        end
        chk("t3_period", period4, 3);
        chk("t3_high",   high4,   1);
        chk("t3_low",    low4,    2);
        chk("t3_odd",    odd4,    1);

        // rise coincides with saturation: rise wins, PERIOD = 15
        rearm(1'b1);
        run_wave(1, 14, 34, 1'b1, "sat_valid");
        chk("sat_period",  period4,  15);
        chk("sat_high",    high4,    1);
        chk("sat_low",     low4,     14);
        chk("sat_odd",     odd4,     1);
        chk("sat_timeout", timeout4, 0);

        // timeout then EN low clears it, outputs hold
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("en_clr_pre_timeout", timeout4, 1);
        chk("en_clr_pre_period",  period4,  15);
        en4 = 1'b0;
        step(1'b0);
        chk("en_clr_timeout", timeout4, 0);
        chk("en_clr_period",  period4,  15);
        chk("en_clr_valid",   valid4,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
